// File: rtl/plat_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plat_scan_pkg
//  Brief    : Shared geometry, sizing and FSM encodings for the platform
//             collision scheduler (plat_scan_ctrl / plat_hit_unit).
//  Revision : 1.0 - initial release
// ============================================================================
package plat_scan_pkg;

    // Frame sizing
    localparam int NUM_PLAT   = 7;
    localparam int X_W        = 14;
    localparam int Y_W        = 15;
    localparam int LEN_W      = 4;
    localparam int IDX_W      = $clog2(NUM_PLAT + 1);

    // Geometry in pixels
    localparam int BLOCK_W    = 16;
    localparam int PLAT_H     = 8;
    localparam int CHAR_W     = 32;
    localparam int CHAR_H     = 32;
    localparam int LAND_TOL   = 8;

    // The ground is reported as one index past the last real platform
    localparam int GROUND_IDX = NUM_PLAT;

    // Scheduler FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : plat_scan_pkg
`default_nettype wire

// File: rtl/plat_hit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : plat_hit_unit
//  Brief    : Combinational landing / head-bump check of the character
//             against a single platform. Time-shared by plat_scan_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module plat_hit_unit
    import plat_scan_pkg::*;
(
    input  logic [X_W-1:0]   cx,
    input  logic [Y_W-1:0]   cy,
    input  logic [X_W-1:0]   px,
    input  logic [Y_W-1:0]   py,
    input  logic [LEN_W-1:0] len,
    output logic             land,
    output logic             head,
    output logic [Y_W-1:0]   surf_y
);

    // One extra bit on each axis so right edges and head tops never wrap
    localparam int XE_W = X_W + 1;
    localparam int YE_W = Y_W + 1;

    logic [XE_W-1:0] w_cx_l;
    logic [XE_W-1:0] w_cx_r;
    logic [XE_W-1:0] w_px_l;
    logic [XE_W-1:0] w_px_r;
    logic [YE_W-1:0] w_cy;
    logic [YE_W-1:0] w_py;
    logic [YE_W-1:0] w_top;
    logic [YE_W-1:0] w_under;
    logic            w_en;
    logic            w_overlap;
    logic            w_land;

    // Span overlap, landing window and underside window for one platform
    always_comb begin
        w_cx_l    = XE_W'(cx);
        w_cx_r    = w_cx_l + XE_W'(CHAR_W - 1);
        w_px_l    = XE_W'(px);
        // Only meaningful for len != 0, which gates every use below
        w_px_r    = w_px_l + XE_W'(len) * XE_W'(BLOCK_W) - XE_W'(1);
        w_en      = (len != '0);
        w_overlap = w_en && (w_px_l <= w_cx_r) && (w_cx_l <= w_px_r);

        w_cy      = YE_W'(cy);
        w_py      = YE_W'(py);
        w_land    = w_overlap && (w_cy <= w_py) && ((w_py - w_cy) <= YE_W'(LAND_TOL));

        w_top     = w_cy + YE_W'(CHAR_H - 1);
        // Platforms sitting close to y=0 clamp their underside at 0
        w_under   = (w_py >= YE_W'(PLAT_H - 1)) ? (w_py - YE_W'(PLAT_H - 1)) : '0;

        land      = w_land;
        head      = w_overlap && !w_land && (w_top >= w_under) && (w_top <= w_py);
        surf_y    = py;
    end

endmodule : plat_hit_unit
`default_nettype wire

// File: rtl/plat_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : plat_scan_ctrl
//  Brief    : Collision scheduler. Snapshots character and platform state on
//             tick, scans one platform per cycle through a shared
//             plat_hit_unit, then reports landing surface and head bump.
//             Optional build macro PLAT_SCAN_STATS_EN adds drop_cnt, a
//             saturating count of ticks ignored while a scan is in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module plat_scan_ctrl
    import plat_scan_pkg::*;
(
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      tick,
    input  logic [X_W-1:0]            char_x,
    input  logic [Y_W-1:0]            char_y,
    input  logic [NUM_PLAT*X_W-1:0]   plat_x,
    input  logic [NUM_PLAT*Y_W-1:0]   plat_y,
    input  logic [NUM_PLAT*LEN_W-1:0] plat_len,
    output logic                      busy,
    output logic                      res_valid,
    output logic                      land_hit,
    output logic [IDX_W-1:0]          land_idx,
    output logic [Y_W-1:0]            land_y,
    output logic                      head_hit
`ifdef PLAT_SCAN_STATS_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    logic [1:0]                r_state;
    logic [1:0]                w_next;
    logic [IDX_W-1:0]          r_idx;

    // Snapshot taken on an accepted tick
    logic [X_W-1:0]            r_cx;
    logic [Y_W-1:0]            r_cy;
    logic [NUM_PLAT*X_W-1:0]   r_px_bus;
    logic [NUM_PLAT*Y_W-1:0]   r_py_bus;
    logic [NUM_PLAT*LEN_W-1:0] r_len_bus;

    // Scan accumulators
    logic                      r_best_hit;
    logic [IDX_W-1:0]          r_best_idx;
    logic [Y_W-1:0]            r_best_y;
    logic                      r_head_acc;

    // Committed results, held between res_valid pulses
    logic                      r_land_hit;
    logic [IDX_W-1:0]          r_land_idx;
    logic [Y_W-1:0]            r_land_y;
    logic                      r_head_hit;

    logic [X_W-1:0]            w_cur_px;
    logic [Y_W-1:0]            w_cur_py;
    logic [LEN_W-1:0]          w_cur_len;
    logic                      w_land;
    logic                      w_head;
    logic [Y_W-1:0]            w_surf_y;
    logic                      w_accept;
    logic                      w_gnd_land;
    logic                      w_fin_hit;
    logic [IDX_W-1:0]          w_fin_idx;
    logic [Y_W-1:0]            w_fin_y;

    assign w_accept   = (r_state == ST_IDLE) && tick;
    assign w_cur_px   = r_px_bus[int'(r_idx) * X_W +: X_W];
    assign w_cur_py   = r_py_bus[int'(r_idx) * Y_W +: Y_W];
    assign w_cur_len  = r_len_bus[int'(r_idx) * LEN_W +: LEN_W];

    // The ground only matters when no real platform offered a landing
    assign w_gnd_land = (r_cy == '0);
    assign w_fin_hit  = r_best_hit || w_gnd_land;
    assign w_fin_idx  = r_best_hit ? r_best_idx : (w_gnd_land ? IDX_W'(GROUND_IDX) : '0);
    assign w_fin_y    = r_best_hit ? r_best_y : '0;

    plat_hit_unit u_hit (
        .cx     (r_cx),
        .cy     (r_cy),
        .px     (w_cur_px),
        .py     (w_cur_py),
        .len    (w_cur_len),
        .land   (w_land),
        .head   (w_head),
        .surf_y (w_surf_y)
    );

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (tick) w_next = ST_SCAN;
            ST_SCAN: if (r_idx == IDX_W'(NUM_PLAT - 1)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: results are shown live in DONE, then held from registers
    always_comb begin
        busy      = (r_state == ST_SCAN);
        res_valid = (r_state == ST_DONE);
        land_hit  = r_land_hit;
        land_idx  = r_land_idx;
        land_y    = r_land_y;
        head_hit  = r_head_hit;
        if (r_state == ST_DONE) begin
            land_hit = w_fin_hit;
            land_idx = w_fin_idx;
            land_y   = w_fin_y;
            head_hit = r_head_acc;
        end
    end

    // Snapshot, scan index and accumulator datapath
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_idx      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_px_bus   <= '0;
            r_py_bus   <= '0;
            r_len_bus  <= '0;
            r_best_hit <= 1'b0;
            r_best_idx <= '0;
            r_best_y   <= '0;
            r_head_acc <= 1'b0;
        end else if (w_accept) begin
            r_idx      <= '0;
            r_cx       <= char_x;
            r_cy       <= char_y;
            r_px_bus   <= plat_x;
            r_py_bus   <= plat_y;
            r_len_bus  <= plat_len;
            r_best_hit <= 1'b0;
            r_best_idx <= '0;
            r_best_y   <= '0;
            r_head_acc <= 1'b0;
        end else if (r_state == ST_SCAN) begin
            r_idx <= r_idx + IDX_W'(1);
            // Strictly higher surface wins, so ties keep the lower index
            if (w_land && (!r_best_hit || (w_surf_y > r_best_y))) begin
                r_best_hit <= 1'b1;
                r_best_idx <= r_idx;
                r_best_y   <= w_surf_y;
            end
            if (w_head) begin
                r_head_acc <= 1'b1;
            end
        end
    end

    // Result registers, committed as DONE is left
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_land_hit <= 1'b0;
            r_land_idx <= '0;
            r_land_y   <= '0;
            r_head_hit <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_land_hit <= w_fin_hit;
            r_land_idx <= w_fin_idx;
            r_land_y   <= w_fin_y;
            r_head_hit <= r_head_acc;
        end
    end

`ifdef PLAT_SCAN_STATS_EN
    logic [7:0] r_drop_cnt;

    // Count ticks that arrive while SCAN or DONE is in progress, saturating
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_drop_cnt <= '0;
        end else if (tick && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule : plat_scan_ctrl
`default_nettype wire
